// File: rtl/wordle_round_ctrl.sv
// wordle_round_ctrl: digit-Wordle game sequencer (target load, guess entry, per-position compare)
module wordle_round_ctrl #(
  parameter int DIGITS = 5,
  parameter int DW = 4,
  parameter int MAX_TRIES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_mode,
  input  logic [DW-1:0]          digit_in,
  input  logic                   digit_enter,
  input  logic                   submit,
  output logic [DIGITS*DW-1:0]   word_out,
  output logic [3:0]             tries_out,
  output logic [2*DIGITS-1:0]    result,
  output logic                   result_valid,
  output logic                   warning,
  output logic [1:0]             state_out,
  output logic                   busy
);
  localparam int CW = $clog2(DIGITS + 1);
  typedef enum logic [2:0] {S_IDLE, S_SET, S_GUESS, S_CMP, S_RES, S_WIN, S_LOSE} state_t;
  state_t state, state_nxt;
  logic [DIGITS-1:0][DW-1:0] word, tgt;
  logic [DIGITS-1:0][1:0] res, res_nxt;
  logic [CW-1:0] cnt, idx;
  logic [DW-1:0] g;
  logic [1:0] code;
  logic hit, legal, room, full, last;
  logic warn_nxt, wr, first, load_tgt, start_cmp, clr_game;

  assign word_out = word;
  assign result = res;
  assign busy = state == S_CMP;
  assign state_out = state == S_WIN ? 2'b10 : state == S_LOSE ? 2'b11 :
                     (state == S_IDLE || state == S_SET) ? 2'b00 : 2'b01;

  // Scoring of the position selected by idx, plus entry-legality flags
  always_comb begin
    g = word[idx];
    hit = 1'b0;
    for (int j = 0; j < DIGITS; j++) hit = hit | (tgt[j] == g);
    code = g == tgt[idx] ? 2'b11 : hit ? 2'b10 : 2'b01;
    res_nxt = res;
    res_nxt[idx] = code;
    legal = digit_in <= DW'(9);
    room = cnt < CW'(DIGITS);
    full = cnt == CW'(DIGITS);
    last = idx == CW'(DIGITS - 1);
  end

  // Next state and datapath strobes; submit always outranks a same-cycle digit
  always_comb begin
    state_nxt = state;
    warn_nxt = 1'b0;
    wr = 1'b0;
    first = 1'b0;
    load_tgt = 1'b0;
    start_cmp = 1'b0;
    clr_game = 1'b0;
    case (state)
      S_IDLE: begin
        first = !submit && digit_enter && set_mode && legal;
        wr = first;
        warn_nxt = submit || (digit_enter && !first);
        state_nxt = first ? S_SET : S_IDLE;
      end
      S_SET, S_GUESS: begin
        wr = !submit && digit_enter && legal && room;
        warn_nxt = submit ? (digit_enter || !full) : (digit_enter && !wr);
        load_tgt = submit && full && state == S_SET;
        start_cmp = submit && full && state == S_GUESS;
        state_nxt = load_tgt ? S_GUESS : start_cmp ? S_CMP : state;
      end
      S_CMP: state_nxt = !last ? S_CMP : &res_nxt ? S_WIN :
                         tries_out == 4'(MAX_TRIES) ? S_LOSE : S_RES;
      S_RES: begin
        first = !submit && digit_enter && legal;
        wr = first;
        warn_nxt = submit || (digit_enter && !legal);
        state_nxt = first ? S_GUESS : S_RES;
      end
      default: begin
        clr_game = submit && set_mode;
        state_nxt = clr_game ? S_IDLE : state;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nxt;

  // Word entry, target capture, attempt counting and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '1;
      tgt <= '0;
      res <= '0;
      cnt <= '0;
      idx <= '0;
      tries_out <= '0;
      result_valid <= 1'b0;
      warning <= 1'b0;
    end else begin
      warning <= warn_nxt;
      if (wr && first) begin
        word <= '1;
        word[0] <= digit_in;
        cnt <= CW'(1);
        result_valid <= 1'b0;
      end else if (wr) begin
        word[cnt] <= digit_in;
        cnt <= cnt + 1'b1;
      end
      if (load_tgt || clr_game) begin
        word <= '1;
        cnt <= '0;
      end
      if (load_tgt) tgt <= word;
      if (clr_game) begin
        tgt <= '0;
        tries_out <= '0;
        res <= '0;
        result_valid <= 1'b0;
      end
      if (start_cmp) begin
        tries_out <= tries_out + 4'd1;
        res <= '0;
        result_valid <= 1'b0;
        idx <= '0;
      end
      if (state == S_CMP) begin
        res <= res_nxt;
        idx <= idx + 1'b1;
        result_valid <= last;
      end
    end
  end
endmodule

// File: tb/tb_wordle_round_ctrl.sv
// tb_wordle_round_ctrl: table-driven and sequence checks of the Wordle round controller
module tb_wordle_round_ctrl;
  logic clk = 0, rst = 1, set_mode = 0, digit_enter = 0, submit = 0;
  logic [3:0] digit_in = 0;
  logic [19:0] word_out;
  logic [3:0] tries_out;
  logic [9:0] result;
  logic result_valid, warning, busy;
  logic [1:0] state_out;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wordle_round_ctrl dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .digit_in(digit_in),
    .digit_enter(digit_enter), .submit(submit), .word_out(word_out),
    .tries_out(tries_out), .result(result), .result_valid(result_valid),
    .warning(warning), .state_out(state_out), .busy(busy)
  );

  typedef struct {
    logic sm; logic [3:0] d; logic de; logic sb;
    logic [1:0] st; logic [19:0] w; logic [3:0] tr; logic wn; logic [9:0] res; logic rv; logic bz;
  } vec_t;
  vec_t tv[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(logic sm, logic [3:0] d, logic de, logic sb);
    @(negedge clk);
    set_mode = sm; digit_in = d; digit_enter = de; submit = sb;
    @(posedge clk);
    #1;
    set_mode = 0; digit_enter = 0; submit = 0;
  endtask

  task automatic enter(logic [19:0] w, logic sm);
    for (int i = 0; i < 5; i++) step(i == 0 ? sm : 1'b0, w[4*i +: 4], 1, 0);
    step(0, 0, 0, 1);
  endtask

  task automatic wait_idle_busy(string tag);
    int n = 0;
    while (busy && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (busy) chk({tag, ".timeout"}, 1, 0);
  endtask

  initial begin
    tv.push_back('{1, 1, 1, 0, 0, 20'hFFFF1, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 2, 1, 0, 0, 20'hFFF21, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 4'hA, 1, 0, 0, 20'hFFF21, 0, 1, 10'h000, 0, 0});
    tv.push_back('{0, 3, 1, 0, 0, 20'hFF321, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 0, 0, 1, 0, 20'hFF321, 0, 1, 10'h000, 0, 0});
    tv.push_back('{0, 4, 1, 0, 0, 20'hF4321, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 5, 1, 0, 0, 20'h54321, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 6, 1, 0, 0, 20'h54321, 0, 1, 10'h000, 0, 0});
    tv.push_back('{0, 0, 0, 1, 1, 20'hFFFFF, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 5, 1, 0, 1, 20'hFFFF5, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 2, 1, 0, 1, 20'hFFF25, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 9, 1, 0, 1, 20'hFF925, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 9, 1, 0, 1, 20'hF9925, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 1, 1, 0, 1, 20'h19925, 0, 0, 10'h000, 0, 0});
    tv.push_back('{0, 0, 0, 1, 1, 20'h19925, 1, 0, 10'h000, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h19925, 1, 0, 10'h002, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h19925, 1, 0, 10'h00E, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h19925, 1, 0, 10'h01E, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h19925, 1, 0, 10'h05E, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h19925, 1, 0, 10'h25E, 1, 0});
    tv.push_back('{0, 0, 0, 1, 1, 20'h19925, 1, 1, 10'h25E, 1, 0});
    tv.push_back('{0, 4'hA, 1, 0, 1, 20'h19925, 1, 1, 10'h25E, 1, 0});
    tv.push_back('{0, 1, 1, 0, 1, 20'hFFFF1, 1, 0, 10'h25E, 0, 0});
    tv.push_back('{0, 2, 1, 0, 1, 20'hFFF21, 1, 0, 10'h25E, 0, 0});
    tv.push_back('{0, 3, 1, 0, 1, 20'hFF321, 1, 0, 10'h25E, 0, 0});
    tv.push_back('{0, 4, 1, 0, 1, 20'hF4321, 1, 0, 10'h25E, 0, 0});
    tv.push_back('{0, 5, 1, 0, 1, 20'h54321, 1, 0, 10'h25E, 0, 0});
    tv.push_back('{0, 7, 1, 1, 1, 20'h54321, 2, 1, 10'h000, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h54321, 2, 0, 10'h003, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h54321, 2, 0, 10'h00F, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h54321, 2, 0, 10'h03F, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 20'h54321, 2, 0, 10'h0FF, 0, 1});
    tv.push_back('{0, 0, 0, 0, 2, 20'h54321, 2, 0, 10'h3FF, 1, 0});
    tv.push_back('{0, 3, 1, 0, 2, 20'h54321, 2, 0, 10'h3FF, 1, 0});
    tv.push_back('{1, 0, 0, 1, 0, 20'hFFFFF, 0, 0, 10'h000, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", state_out, 0);
    chk("rst.word", word_out, 20'hFFFFF);
    chk("rst.tries", tries_out, 0);
    chk("rst.result", result, 0);
    chk("rst.rv", result_valid, 0);
    chk("rst.warn", warning, 0);
    chk("rst.busy", busy, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].sm, tv[i].d, tv[i].de, tv[i].sb);
      chk($sformatf("v%0d.state", i), state_out, tv[i].st);
      chk($sformatf("v%0d.word", i), word_out, tv[i].w);
      chk($sformatf("v%0d.tries", i), tries_out, tv[i].tr);
      chk($sformatf("v%0d.warn", i), warning, tv[i].wn);
      chk($sformatf("v%0d.result", i), result, tv[i].res);
      chk($sformatf("v%0d.rv", i), result_valid, tv[i].rv);
      chk($sformatf("v%0d.busy", i), busy, tv[i].bz);
    end

    begin
      int n = 0;
      enter(20'h54321, 1);
      enter(20'h54321, 0);
      for (int k = 0; k < 20; k++) begin
        if (!busy) break;
        n++;
        step(0, 0, 0, 0);
      end
      chk("win.busy_cycles", n, 5);
      chk("win.state", state_out, 2);
      chk("win.tries", tries_out, 1);
      chk("win.result", result, 10'h3FF);
      chk("win.rv", result_valid, 1);
    end

    step(1, 0, 0, 1);
    chk("clr.state", state_out, 0);
    enter(20'h54321, 1);
    for (int g = 1; g <= 6; g++) begin
      enter(20'h66666, 0);
      wait_idle_busy($sformatf("lose%0d", g));
      chk($sformatf("lose%0d.result", g), result, 10'h155);
      chk($sformatf("lose%0d.tries", g), tries_out, g);
      chk($sformatf("lose%0d.state", g), state_out, g < 6 ? 2'd1 : 2'd3);
    end
    step(0, 2, 1, 0);
    chk("lose.ign.warn", warning, 0);
    chk("lose.ign.state", state_out, 3);
    chk("lose.ign.word", word_out, 20'h66666);
    chk("lose.ign.tries", tries_out, 6);

    step(1, 0, 0, 1);
    enter(20'h54321, 1);
    enter(20'h11111, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("mid.busy", busy, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid.state", state_out, 0);
    chk("mid.busy0", busy, 0);
    chk("mid.result", result, 0);
    chk("mid.tries", tries_out, 0);
    chk("mid.word", word_out, 20'hFFFFF);
    chk("mid.rv", result_valid, 0);
    @(negedge clk);
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
